alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters (e.g. the execute stage and the address/branch unit).
- Arbitrates round-robin and latches the winner's opcode and operands.
- Drives the ALU for one cycle, then returns the registered result/zero flag with a one-cycle done pulse to the winner.
- Sits between the requesters and the ALU instance in the datapath top level.

Parameters:
- n, 32, data width; must match the ALU's n.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req0  input  1  requester 0 request; held high until done0.
- op0  input  3  requester 0 ALU control code.
- a0  input  n  requester 0 operand A.
- b0  input  n  requester 0 operand B.
- req1, op1, a1, b1  input  1/3/n/n  same meaning for requester 1.
- alu_ctrl  output  3  ALUCtrl driven to the ALU.
- alu_opa  output  n  OPA driven to the ALU.
- alu_opb  output  n  OPB driven to the ALU.
- alu_result  input  n  ALU Result.
- alu_zero  input  1  ALU Zero.
- result  output  n  registered result of the last completed operation.
- zero  output  1  registered zero flag of the last completed operation.
- done0  output  1  one-cycle pulse: result/zero valid for requester 0.
- done1  output  1  one-cycle pulse: result/zero valid for requester 1.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state=IDLE, last=1 (requester 0 wins the first tie), op_r=3'b000, opa_r=0, opb_r=0, result=0, zero=0, done0=0, done1=0, busy=0.
- States: IDLE, EXEC, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not `last`.
  - On grant: latch op/a/b of the winner into op_r/opa_r/opb_r, set owner=winner, set last=winner, go to EXEC.
- EXEC:
  - alu_ctrl=op_r, alu_opa=opa_r, alu_opb=opb_r.
  - At the clock edge: result<=alu_result, zero<=alu_zero, done<owner><=1, go to DONE.
- DONE:
  - done<owner> is high for exactly this cycle; result and zero are stable.
  - req inputs are ignored this cycle, so a requester that drops req on seeing done is never re-granted.
  - Next state is IDLE; done is cleared.
- ALU drive outside EXEC: alu_ctrl=3'b000, alu_opa=0, alu_opb=0, so the ALU outputs Result=0.
- Latency: req sampled high in IDLE at cycle t → done pulse in cycle t+2 → IDLE again at t+3. Throughput is one operation per 3 cycles.
- Held operands: result and zero hold their values until the next EXEC edge.
- Operand changes after grant: changes to opX, aX or bX after the grant cycle have no effect on the operation in flight.
- Unsupported opcodes (000, 001, 010): passed through unchanged. The ALU returns 0, so result=0, zero=1 and done still pulses.
- Width rules: no width conversion is performed.
  - Shift (111) uses the full opb_r as the shift amount; any amount ≥ n gives 0.
  - Add and subtract wrap modulo 2^n; carry is not exported.
- Fairness: with both requesters continuously re-requesting, grants strictly alternate 0,1,0,1…
- Reset mid-operation: rst in EXEC or DONE returns to IDLE with all reset values. No done pulse is issued for the aborted operation, and last=1 again.
- Simultaneous rst and req: rst wins, no grant.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control constants: ALU_ADD=3'b011, ALU_SUB=3'b100, ALU_OR=3'b101, ALU_AND=3'b110, ALU_SHL=3'b111, ALU_NOP=3'b000.
  - State encoding: IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
- One natural sub-module, rr_pick2: combinational 2-way round-robin picker. Inputs req0, req1, last; outputs grant_valid and winner.
- The ALU itself is instantiated beside alu_arbiter in the datapath top level, not inside it.

Test Plan:
- Reset release, req0=1, op0=011, a0=5, b0=7 → done0 pulses at t+2 with result=12, zero=0; done1 never asserts.
- Both requesters requesting at once after reset: req0 op=100 a=9 b=9, req1 op=111 a=1 b=4.
  - First grant goes to 0: result=0, zero=1.
  - Second grant goes to 1: result=16.
  - Grants continue alternating while both requesters hold req.
- req1 op=101 a=32'hF0 b=32'h0F; a1 changed to 0 during EXEC → result=32'hFF (latched operand used).
- Edge cases in a single directed sequence:
  - Wrap-around: op=011, a=32'hFFFFFFFF, b=1 → result=0, zero=1.
  - Oversized shift: op=111, a=1, b=40 → result=0.
  - Unsupported opcode: op=010 → result=0, zero=1, done pulses.
- rst asserted in the EXEC cycle → no done pulse; all outputs return to reset values next cycle; the following simultaneous request is granted to requester 0.
- Requester holds req through DONE, then keeps it high → DONE cycle ignored; it is re-granted in the following IDLE cycle only.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes and arbiter state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_SHL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and completion signals of the ALU arbiter.
// slave: the arbiter side; master: the requesters plus the ALU.
interface alu_arbiter_if #(
    parameter int unsigned n = 32
);
    logic         req0;
    logic [2:0]   op0;
    logic [n-1:0] a0;
    logic [n-1:0] b0;
    logic         req1;
    logic [2:0]   op1;
    logic [n-1:0] a1;
    logic [n-1:0] b1;
    logic [2:0]   alu_ctrl;
    logic [n-1:0] alu_opa;
    logic [n-1:0] alu_opb;
    logic [n-1:0] alu_result;
    logic         alu_zero;
    logic [n-1:0] result;
    logic         zero;
    logic         done0;
    logic         done1;
    logic         busy;

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
        output alu_ctrl, alu_opa, alu_opb, result, zero, done0, done1, busy
    );

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1, alu_result, alu_zero,
        input  alu_ctrl, alu_opa, alu_opb, result, zero, done0, done1, busy
    );
endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic winner
);
    // Single request wins outright; a tie goes to the one that is not last.
    always_comb begin
        grant_valid = req0 | req1;
        winner      = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant, drive for one
// cycle, register the result and pulse done to the winner.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_if.slave   bus
);
    state_t       state;
    logic         last;
    logic         owner;
    logic [2:0]   op_r;
    logic [n-1:0] opa_r;
    logic [n-1:0] opb_r;
    logic [n-1:0] result_r;
    logic         zero_r;
    logic         done0_r;
    logic         done1_r;
    logic         grant_valid;
    logic         winner;

    rr_pick2 u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last        (last),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // Arbitration FSM: IDLE grants and latches, EXEC captures the ALU, DONE pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            op_r     <= ALU_NOP;
            opa_r    <= '0;
            opb_r    <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
            done0_r  <= 1'b0;
            done1_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        op_r  <= winner ? bus.op1 : bus.op0;
                        opa_r <= winner ? bus.a1  : bus.a0;
                        opb_r <= winner ? bus.b1  : bus.b0;
                        owner <= winner;
                        last  <= winner;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result_r <= bus.alu_result;
                    zero_r   <= bus.alu_zero;
                    if (owner) begin
                        done1_r <= 1'b1;
                    end else begin
                        done0_r <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    done0_r <= 1'b0;
                    done1_r <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ALU sees the latched operation only during EXEC; otherwise a NOP with zero operands.
    always_comb begin
        bus.alu_ctrl = ALU_NOP;
        bus.alu_opa  = '0;
        bus.alu_opb  = '0;
        if (state == EXEC) begin
            bus.alu_ctrl = op_r;
            bus.alu_opa  = opa_r;
            bus.alu_opb  = opb_r;
        end
    end

    assign bus.result = result_r;
    assign bus.zero   = zero_r;
    assign bus.done0  = done0_r;
    assign bus.done1  = done1_r;
    assign bus.busy   = (state != IDLE);

endmodule
